// File: rtl/wb_regs_pkg.sv
// Shared widths, constants and write-port record for the writeback register block.
// GPR/HI/LO/LLbit all use these so no file carries a literal width.
package wb_regs_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int RegWidth  = 32;
  localparam int AddrWidth = 5;
  localparam int RegNum    = 32;

  typedef logic [RegWidth-1:0]  RegBus;
  typedef logic [AddrWidth-1:0] RegAddrBus;

  localparam RegBus     ZeroWord = '0;
  localparam RegAddrBus ZeroAddr = '0;

  typedef struct packed {
    logic      we;
    RegAddrBus addr;
    RegBus     data;
  } gpr_wr_t;

  // A write is architecturally visible only when enabled and not aimed at r0.
  function automatic logic gpr_wr_live(input gpr_wr_t wr);
    return (wr.we == WriteEnable) && (wr.addr != ZeroAddr);
  endfunction

  function automatic logic gpr_wr_hits(input gpr_wr_t wr, input RegAddrBus addr);
    return gpr_wr_live(wr) && (wr.addr == addr);
  endfunction

endpackage

// File: rtl/wb_regs_regfile.sv
// 32-entry GPR array, two combinational read ports with write-through bypass.
// Writes land one edge later; r0 is hardwired to zero.
module regfile
  import wb_regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  gpr_wr_t   wr,
  input  logic      re1,
  input  RegAddrBus raddr1,
  input  logic      re2,
  input  RegAddrBus raddr2,
  output RegBus     rdata1,
  output RegBus     rdata2
);

  RegBus regs_q [RegNum];
  RegBus regs_d [RegNum];

  always_comb begin
    regs_d = regs_q;
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        regs_d[i] = ZeroWord;
      end
    end else if (gpr_wr_live(wr)) begin
      regs_d[wr.addr] = wr.data;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Reset and r0 take priority over the bypass so neither can leak write data.
  function automatic RegBus read_port(input logic re, input RegAddrBus addr);
    RegBus val;
    val = ZeroWord;
    if (rst == RstEnable || re != WriteEnable || addr == ZeroAddr) begin
      val = ZeroWord;
    end else if (gpr_wr_hits(wr, addr)) begin
      val = wr.data;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

endmodule

// File: rtl/wb_regs.sv
// Writeback-stage architectural state: GPR file, HI/LO pair and the LL/SC link bit.
// HI/LO are presented unbypassed; LLbit is bypassed so the memory stage sees same-cycle updates.
module wb_regs
  import wb_regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_wreg,
  input  RegAddrBus wb_wd,
  input  RegBus     wb_wdata,
  input  logic      wb_whilo,
  input  RegBus     wb_hi,
  input  RegBus     wb_lo,
  input  logic      wb_LLbit_we,
  input  logic      wb_LLbit_value,
  input  logic      flush,
  input  logic      re1,
  input  logic      re2,
  input  RegAddrBus raddr1,
  input  RegAddrBus raddr2,
  output RegBus     rdata1,
  output RegBus     rdata2,
  output RegBus     hi_o,
  output RegBus     lo_o,
  output logic      LLbit_o
);

  logic    rst;
  gpr_wr_t gpr_wr;

  RegBus hi_q, hi_d;
  RegBus lo_q, lo_d;
  logic  llbit_q, llbit_d;
  logic  llbit_next;

  // rst_n is active-high in this pipeline despite its name.
  assign rst = (rst_n == RstEnable);

  always_comb begin
    gpr_wr      = '0;
    gpr_wr.we   = wb_wreg;
    gpr_wr.addr = wb_wd;
    gpr_wr.data = wb_wdata;
  end

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wr     (gpr_wr),
    .re1    (re1),
    .raddr1 (raddr1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Flush clears the link even when a write arrives in the same cycle.
  always_comb begin
    llbit_next = llbit_q;
    if (flush) begin
      llbit_next = 1'b0;
    end else if (wb_LLbit_we == WriteEnable) begin
      llbit_next = wb_LLbit_value;
    end
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    llbit_d = llbit_next;
    if (rst) begin
      hi_d    = ZeroWord;
      lo_d    = ZeroWord;
      llbit_d = 1'b0;
    end else if (wb_whilo == WriteEnable) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    llbit_q <= llbit_d;
  end

  always_comb begin
    hi_o    = rst ? ZeroWord : hi_q;
    lo_o    = rst ? ZeroWord : lo_q;
    LLbit_o = rst ? 1'b0 : llbit_next;
  end

endmodule
